hamming74_rx_ctrl: RTL and testbench

Receive-side controller for the Hamming(7,4) decode datapath. It accepts 7-bit codewords over a valid/ready stream and sequences each word through capture, syndrome and emit steps. It corrects any single-bit error and returns 4-bit data with the syndrome and a corrected flag over a second valid/ready stream. It also keeps saturating word and error statistics for software. It sits between the channel/deserializer and the data consumer.

---
 rtl/hamming74_rx_ctrl_pkg.sv | 45 ++++
 rtl/hamming74_syndrome.sv | 25 ++
 rtl/hamming74_rx_ctrl.sv | 105 ++++++++++
 tb/tb_hamming74_rx_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_rx_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the Hamming(7,4) receive controller.
package hamming74_rx_ctrl_pkg;

  localparam int unsigned CW_W  = 7;
  localparam int unsigned DW_W  = 4;
  localparam int unsigned SYN_W = 3;

  // Hamming positions (1-based) of the parity bits
  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned P4_POS = 4;

  // Codeword bit indices (0-based) carrying data, LSB first
  localparam int unsigned D0_IDX = 2;
  localparam int unsigned D1_IDX = 4;
  localparam int unsigned D2_IDX = 5;
  localparam int unsigned D3_IDX = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYND = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW_W-1:0]  data;
    logic [SYN_W-1:0] syndrome;
    logic             corrected;
  } rx_result_t;

  // Codeword bits whose Hamming position includes the given parity position
  function automatic logic [CW_W-1:0] cover_mask(input int unsigned ppos);
    logic [CW_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < CW_W; i++) begin
      m[i] = (((i + 1) & ppos) != 0);
    end
    return m;
  endfunction

  function automatic logic [DW_W-1:0] extract_data(input logic [CW_W-1:0] c);
    return {c[D3_IDX], c[D2_IDX], c[D1_IDX], c[D0_IDX]};
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational syndrome calculation and single-bit correction for one codeword.
module hamming74_syndrome
  import hamming74_rx_ctrl_pkg::*;
(
  input  logic [CW_W-1:0]  i_code,
  output logic [SYN_W-1:0] o_syndrome,
  output logic [CW_W-1:0]  o_corr_code
);

  localparam logic [CW_W-1:0] MASK_S1 = cover_mask(P1_POS);
  localparam logic [CW_W-1:0] MASK_S2 = cover_mask(P2_POS);
  localparam logic [CW_W-1:0] MASK_S4 = cover_mask(P4_POS);

  logic [SYN_W-1:0] w_syn;
  logic [CW_W-1:0]  w_flip;

  assign w_syn = {^(i_code & MASK_S4), ^(i_code & MASK_S2), ^(i_code & MASK_S1)};

  // A nonzero syndrome names the 1-based position of the bit to invert
  assign w_flip = (w_syn == '0) ? '0 : (CW_W'(1) << (w_syn - SYN_W'(1)));

  assign o_syndrome  = w_syn;
  assign o_corr_code = i_code ^ w_flip;

endmodule

// File: rtl/hamming74_rx_ctrl.sv
// Hamming(7,4) receive controller: capture, syndrome/correct, emit, with saturating stats.
module hamming74_rx_ctrl
  import hamming74_rx_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW_W-1:0]  out_data,
  output logic [SYN_W-1:0] out_syndrome,
  output logic             out_corrected,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  logic [CW_W-1:0]  r_code;
  rx_result_t       r_out;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [SYN_W-1:0] w_syn;
  logic [CW_W-1:0]  w_corr_code;
  logic             w_accept;
  logic             w_handshake;

  hamming74_syndrome u_syndrome (
    .i_code      (r_code),
    .o_syndrome  (w_syn),
    .o_corr_code (w_corr_code)
  );

  // Ready only while idle; held low during reset so nothing is accepted then
  assign in_ready    = !rst && enable && (r_state == ST_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_code      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code  <= in_code;
            r_state <= ST_SYND;
          end
        end
        ST_SYND: begin
          r_out.data      <= extract_data(w_corr_code);
          r_out.syndrome  <= w_syn;
          r_out.corrected <= (w_syn != '0);
          r_out_valid     <= 1'b1;
          r_state         <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics advance on the output handshake; a clear in the same cycle wins
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_handshake) begin
      if (r_word_cnt != CNT_MAX) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (r_out.corrected && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out.data;
  assign out_syndrome  = r_out.syndrome;
  assign out_corrected = r_out.corrected;
  assign word_cnt      = r_word_cnt;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_hamming74_rx_ctrl.sv
// Self-checking bench for hamming74_rx_ctrl against a positional Hamming reference model.
module tb_hamming74_rx_ctrl;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CNT_W2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, enable, in_valid, out_ready, clr_cnt;
  logic [6:0]       in_code;
  logic             in_ready, out_valid, out_corrected;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic [CNT_W-1:0] word_cnt, err_cnt;

  logic              s_in_ready, s_out_valid, s_out_corrected;
  logic [3:0]        s_out_data;
  logic [2:0]        s_out_syndrome;
  logic [CNT_W2-1:0] s_word_cnt, s_err_cnt;

  hamming74_rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected), .clr_cnt(clr_cnt),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation
  hamming74_rx_ctrl #(.CNT_W(CNT_W2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_code(in_code), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_syndrome(s_out_syndrome), .out_corrected(s_out_corrected), .clr_cnt(clr_cnt),
    .word_cnt(s_word_cnt), .err_cnt(s_err_cnt)
  );

  int total = 0;
  int bad   = 0;
  int m_words, m_errs;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
  } exp_t;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference encoder: each parity bit covers the positions whose index contains it
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] c;
    logic       par;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= 7; q++) if (((q & p) != 0) && (q != p)) par ^= c[q-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  // Syndrome as the XOR of the positions of all set bits
  function automatic logic [2:0] ref_syn(input logic [6:0] c);
    int s;
    s = 0;
    for (int q = 1; q <= 7; q++) if (c[q-1]) s ^= q;
    return 3'(s);
  endfunction

  function automatic logic [3:0] ref_data(input logic [6:0] c);
    logic [6:0] f;
    int         s;
    f = c;
    s = int'(ref_syn(c));
    if (s != 0) f[s-1] = ~f[s-1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  function automatic logic [6:0] flip(input logic [6:0] c, input int p);
    return (p == 0) ? c : (c ^ (7'(1) << (p - 1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word through the DUT; lat = edges from accept to out_valid, -1 on timeout
  task automatic xfer(input logic [6:0] code, input int stall, output int lat,
                      output logic [3:0] d, output logic [2:0] s, output logic c,
                      output bit stable);
    int               guard;
    logic [CNT_W-1:0] wc, ec;
    lat = 0; stable = 1'b1; d = '0; s = '0; c = 1'b0;
    in_code = code; in_valid = 1'b1; out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    if (!in_ready) begin in_valid = 1'b0; out_ready = 1'b1; lat = -1; return; end
    step();
    in_valid = 1'b0; in_code = 7'($urandom); lat = 1;
    while (!out_valid && lat < 20) begin step(); lat++; end
    if (!out_valid) begin out_ready = 1'b1; lat = -1; return; end
    d = out_data; s = out_syndrome; c = out_corrected; wc = word_cnt; ec = err_cnt;
    for (int i = 0; i < stall; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== d || out_syndrome !== s || out_corrected !== c ||
          in_ready !== 1'b0 || word_cnt !== wc || err_cnt !== ec) stable = 1'b0;
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; in_code = '0;
    step(); step();
    total++;
    if ({in_ready, out_valid, out_data, out_syndrome, out_corrected} !== 10'd0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {in_ready, out_valid, out_data, out_syndrome, out_corrected});
    end
    total++;
    if (word_cnt !== '0 || err_cnt !== '0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", word_cnt, err_cnt);
    end
    total++;
    if ({s_in_ready, s_out_valid, s_out_data, s_out_syndrome, s_out_corrected, s_word_cnt, s_err_cnt} !== 14'd0) begin
      bad++; $display("FAIL reset_sat_inst got=%b exp=0",
                      {s_in_ready, s_out_valid, s_out_data, s_out_syndrome, s_out_corrected, s_word_cnt, s_err_cnt});
    end
    rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    m_words = 0; m_errs = 0;
  endtask

  task automatic test_clean();
    int lat; logic [3:0] d; logic [2:0] s; logic c; bit st;
    xfer(7'h55, 0, lat, d, s, c, st);
    m_words++;
    total++; if (lat != 2) begin bad++; $display("FAIL clean_latency got=%0d exp=2", lat); end
    total++; if (d !== 4'b1011) begin bad++; $display("FAIL clean_data got=%b exp=1011", d); end
    total++; if (s !== 3'd0 || c !== 1'b0) begin bad++; $display("FAIL clean_synd got=%0d/%b exp=0/0", s, c); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clean_return_idle got=%b%b exp=01", out_valid, in_ready);
    end
    total++; if (word_cnt !== CNT_W'(1) || err_cnt !== CNT_W'(0)) begin
      bad++; $display("FAIL clean_counts got=%0d/%0d exp=1/0", word_cnt, err_cnt);
    end
  endtask

  task automatic test_single_err();
    int lat, p1, p2; logic [3:0] d, dv; logic [2:0] s; logic c; bit st; logic [6:0] code;
    for (int p = 1; p <= 7; p++) begin
      xfer(flip(7'h55, p), 0, lat, d, s, c, st);
      m_words++; m_errs++;
      total++; if (lat != 2) begin bad++; $display("FAIL err_latency pos=%0d got=%0d exp=2", p, lat); end
      total++; if (s !== 3'(p)) begin bad++; $display("FAIL err_syndrome pos=%0d got=%0d exp=%0d", p, s, p); end
      total++; if (d !== 4'b1011) begin bad++; $display("FAIL err_data pos=%0d got=%b exp=1011", p, d); end
      total++; if (c !== 1'b1) begin bad++; $display("FAIL err_corrected pos=%0d got=%b exp=1", p, c); end
    end
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W)) || err_cnt !== CNT_W'(sat(m_errs, CNT_W))) begin
      bad++; $display("FAIL err_counts got=%0d/%0d exp=%0d/%0d", word_cnt, err_cnt, m_words, m_errs);
    end
    // Two flipped bits: miscorrection at the XOR of the two positions
    dv = 4'($urandom); p1 = $urandom_range(1, 7); p2 = (p1 % 7) + 1;
    code = flip(flip(ref_encode(dv), p1), p2);
    xfer(code, 0, lat, d, s, c, st);
    m_words++; m_errs++;
    total++; if (s !== 3'(p1 ^ p2) || c !== 1'b1 || d !== ref_data(code)) begin
      bad++; $display("FAIL double_err got=%0d/%b/%h exp=%0d/1/%h", s, c, d, p1 ^ p2, ref_data(code));
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] d, dv; logic [2:0] s; logic c; bit st;
    dv = 4'($urandom);
    xfer(flip(ref_encode(dv), 3), 5, lat, d, s, c, st);
    m_words++; m_errs++;
    total++; if (lat != 2) begin bad++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b exp=1", st); end
    total++; if (d !== dv || s !== 3'd3 || c !== 1'b1) begin
      bad++; $display("FAIL bp_result got=%h/%0d/%b exp=%h/3/1", d, s, c, dv);
    end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_return_idle got=%b%b exp=01", out_valid, in_ready);
    end
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W)) || err_cnt !== CNT_W'(sat(m_errs, CNT_W))) begin
      bad++; $display("FAIL bp_counts got=%0d/%0d exp=%0d/%0d", word_cnt, err_cnt, m_words, m_errs);
    end
  endtask

  task automatic test_enable();
    logic [3:0] dv; int guard;
    dv = 4'($urandom);
    in_code = ref_encode(dv); in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL en_accept_timeout got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; enable = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== dv) begin
      bad++; $display("FAIL en_emit got=%b/%h exp=1/%h", out_valid, out_data, dv);
    end
    step();
    m_words++;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL en_hold_idle cyc=%0d got=%b%b exp=00", i, in_ready, out_valid);
      end
      step();
    end
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W))) begin
      bad++; $display("FAIL en_count got=%0d exp=%0d", word_cnt, m_words);
    end
    in_valid = 1'b0; enable = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL en_reenable got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int guard;
    in_code = ref_encode(4'($urandom)); in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || word_cnt !== '0 || err_cnt !== '0 || s_word_cnt !== '0) begin
      bad++; $display("FAIL rmid_cleared got=%b/%0d/%0d/%0d exp=0/0/0/0", out_valid, word_cnt, err_cnt, s_word_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_output cyc=%0d got=%b exp=0", i, out_valid); end
    end
    m_words = 0; m_errs = 0;
  endtask

  task automatic test_saturation();
    int lat, p, guard; logic [3:0] d, dv; logic [2:0] s; logic c; bit st;
    for (int i = 0; i < 5; i++) begin
      dv = 4'($urandom); p = $urandom_range(1, 7);
      xfer(flip(ref_encode(dv), p), 0, lat, d, s, c, st);
      m_words++; m_errs++;
      total++; if (s !== 3'(p) || d !== dv) begin
        bad++; $display("FAIL sat_word i=%0d got=%0d/%h exp=%0d/%h", i, s, d, p, dv);
      end
    end
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W)) || err_cnt !== CNT_W'(sat(m_errs, CNT_W))) begin
      bad++; $display("FAIL sat_wide got=%0d/%0d exp=%0d/%0d", word_cnt, err_cnt, m_words, m_errs);
    end
    total++; if (s_word_cnt !== 2'd3 || s_err_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_narrow got=%0d/%0d exp=3/3", s_word_cnt, s_err_cnt);
    end
    xfer(ref_encode(4'($urandom)), 0, lat, d, s, c, st);
    m_words++;
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W)) || err_cnt !== CNT_W'(sat(m_errs, CNT_W)) ||
                 s_word_cnt !== 2'd3 || s_err_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_clean_word got=%0d/%0d/%0d/%0d exp=%0d/%0d/3/3",
                      word_cnt, err_cnt, s_word_cnt, s_err_cnt, m_words, m_errs);
    end
    // Clear coincident with a handshake
    in_code = flip(ref_encode(4'($urandom)), 2); in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    step();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin step(); guard++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_wait_valid got=%b exp=1", out_valid); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    total++; if (out_valid !== 1'b0 || word_cnt !== '0 || err_cnt !== '0 || s_word_cnt !== '0 || s_err_cnt !== '0) begin
      bad++; $display("FAIL clr_on_handshake got=%b/%0d/%0d/%0d/%0d exp=0/0/0/0/0",
                      out_valid, word_cnt, err_cnt, s_word_cnt, s_err_cnt);
    end
    m_words = 0; m_errs = 0;
  endtask

  task automatic test_back_to_back();
    localparam int N = 16;
    exp_t       q[$];
    exp_t       e;
    logic [3:0] dv;
    logic [6:0] cur;
    int         p, last, accepts, cyc;
    enable = 1'b1; out_ready = 1'b1;
    dv = 4'($urandom); p = $urandom_range(0, 7);
    cur = flip(ref_encode(dv), p);
    in_code = cur; in_valid = 1'b1;
    last = -1; accepts = 0; cyc = 0;
    while ((accepts < N || q.size() > 0) && cyc < 300) begin
      if (out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_output cyc=%0d got=%h exp=none", cyc, out_data);
        end else begin
          e = q.pop_front();
          m_words++;
          if (e.s != 0) m_errs++;
          if (out_data !== e.d || out_syndrome !== e.s || out_corrected !== (e.s != 0)) begin
            bad++; $display("FAIL b2b_result cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b",
                            cyc, out_data, out_syndrome, out_corrected, e.d, e.s, e.s != 0);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{d: dv, s: 3'(p)});
        if (last >= 0) begin
          total++;
          if (cyc - last != 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        accepts++;
        dv = 4'($urandom); p = $urandom_range(0, 7);
        cur = flip(ref_encode(dv), p);
      end
      step();
      cyc++;
      in_code = cur;
      if (accepts >= N) in_valid = 1'b0;
    end
    total++; if (cyc >= 300) begin bad++; $display("FAIL b2b_timeout got=%0d exp=<300", cyc); end
    total++; if (word_cnt !== CNT_W'(sat(m_words, CNT_W)) || err_cnt !== CNT_W'(sat(m_errs, CNT_W))) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", word_cnt, err_cnt, m_words, m_errs);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
